sh7034_intc: RTL and testbench
==============================

Name: sh7034_intc

Overview:
On-chip interrupt controller for the SH7034 core. It collects NMI, external IRQ0-3 and the eight SCI0/SCI1 interrupt lines (ERI/RXI/TXI/TEI). It resolves priority and presents a registered level and vector to the CPU, with an acknowledge handshake. Its IPRA, IPRD and ICR registers sit on the same IBUS as the SCI.

Parameters:
- NUM_IRQ, 4: number of external IRQ pins implemented (IRQ0..IRQ3).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  async active-low reset
- CE_R  in  1  rising-phase clock enable (state update)
- CE_F  in  1  falling-phase clock enable (read data capture)
- RES_N  in  1  synchronous soft reset (registers to init)
- NMI  in  1  NMI pin
- IRQ_N  in  NUM_IRQ  external IRQ pins, active-low
- SCI0_IRQ  in  4  {TEI,TXI,RXI,ERI} from SCI channel 0
- SCI1_IRQ  in  4  {TEI,TXI,RXI,ERI} from SCI channel 1
- IBUS_A  in  28  address
- IBUS_DI  in  32  write data
- IBUS_DO  out  32  read data
- IBUS_BA  in  4  byte enables
- IBUS_WE  in  1  write
- IBUS_REQ  in  1  request
- IBUS_BUSY  out  1  always 0
- IBUS_ACT  out  1  register window selected
- INT_LVL  out  4  requested level (0 = none, 15 = NMI)
- INT_VEC  out  8  vector number of the winning source
- INT_REQ  out  1  level > 0 pending
- INT_ACK  in  1  CPU accepts current INT_VEC (single CE_R cycle)

Behaviour:
- Clock and reset: CLK with asynchronous active-low RST_N. All state advances only when CE_R=1. IBUS_DO data is captured on CE_F.
- Register map (word aligned, byte enables honoured):
  - IPRA 0x5FFFF84: IRQ0..IRQ3 priorities in 4-bit fields, [15:12] = IRQ0.
  - IPRD 0x5FFFF8A: [7:4] = SCI0, [3:0] = SCI1; other fields are reserved, read 0.
  - ICR 0x5FFFF8E: bit15 NMIL (pin level, read-only), bit8 NMIE (1 = rising edge), bits[7:4] IRQ0S..IRQ3S (1 = falling edge, 0 = low level).
- Reset values: IPRA=IPRD=0, ICR=0x0000 with NMIL reflecting the pin. Also INT_LVL=0, INT_VEC=0, INT_REQ=0, IBUS_DO=0, all edge latches cleared. RES_N=0 restores the same register values.
- Input sync: NMI and IRQ_N pass through a 2-stage synchroniser on CE_R.
- NMI: the edge selected by NMIE sets the NMI latch. NMI is always level 15, vector 11.
- IRQn:
  - Edge mode: a falling edge sets latch n.
  - Level mode: request = synchronised pin low.
  - Priority = IPRA field; a field of 0 masks the source. Vector = 64+n.
- SCI sources are level-sensitive, taken straight from the inputs, and never cleared by this block.
  - SCI0 vectors 100-103 (ERI, RXI, TXI, TEI), priority IPRD[7:4].
  - SCI1 vectors 104-107, priority IPRD[3:0].
- Arbitration:
  - Combinational maximum over enabled requests.
  - Ties are broken by fixed order: NMI, IRQ0..3, SCI0 ERI/RXI/TXI/TEI, SCI1 ERI/RXI/TXI/TEI.
  - The result is registered into INT_LVL/INT_VEC/INT_REQ on CE_R: one-cycle latency from a latch or pin change to the outputs.
- Acknowledge:
  - INT_ACK on CE_R clears the NMI latch or IRQn edge latch matching the currently registered INT_VEC.
  - Level sources are unaffected; they persist until deasserted at the source.
  - If a new edge on the same source arrives in the ACK cycle, the latch stays set (set wins).
- Writing an ICR IRQnS bit clears latch n.
- A priority change takes effect at the next arbitration cycle.
- INT_ACK with INT_REQ=0 is ignored.
- IBUS_DO = REG_SEL ? registered read data : 0. IBUS_ACT = REG_SEL.

Optional Feature:
SH7034_INTC_IRQOUT_EN
- Defined: adds output IRQOUT_N (1 bit, reset 1), driven low for any pending request with level above the current SR.I mask. The mask is supplied on an added 4-bit input SR_IMASK.
- Undefined: neither port exists and no logic is generated.

Decomposition:
- SH7034_PKG: IPRA_t, IPRD_t and ICR_t structs; *_INIT and *_WMASK constants; vector number constants (VEC_NMI, VEC_IRQ0, VEC_SCI0_ERI, VEC_SCI1_ERI).
- One sub-module, sh7034_intc_arb: pure priority/tie arbiter taking packed {level, vector, valid} per source, instantiated once.

Test Plan:
- IPRD=0x0053, SCI0_IRQ[1] (RXI) asserted → next CE_R: INT_LVL=5, INT_VEC=101, INT_REQ=1. Deassert → INT_REQ=0 one cycle later.
- IPRA=0x3000, ICR=0x0080, falling edge on IRQ_N[0] → INT_LVL=3, INT_VEC=64. INT_ACK → INT_REQ=0 even though the pin stays low.
- IRQ0 and SCI1 both at level 4, both pending → INT_VEC=64. Ack IRQ0 → INT_VEC=104.
- ICR NMIE=1, NMI rising edge while SCI0 at level 15 → INT_LVL=15, INT_VEC=11. After ack, INT_VEC=100 (SCI0 ERI).
- RST_N pulse mid-request → all outputs 0 and latches cleared. Writing IPRA=0xFFFF then reading back → IBUS_DO=0xFFFFFFFF-replicated halfword.
- Edge arriving in the same cycle as INT_ACK for that IRQ → INT_REQ remains 1 with the same vector.

Source files
------------

// File: rtl/sh7034_intc_pkg.sv
// sh7034_intc_pkg: register layouts, init/write masks, vector numbers and the
// arbiter source record shared by the interrupt controller files.
package sh7034_intc_pkg;

  typedef struct packed {
    logic [3:0] irq0;
    logic [3:0] irq1;
    logic [3:0] irq2;
    logic [3:0] irq3;
  } ipra_t;

  typedef struct packed {
    logic [7:0] rsv;
    logic [3:0] sci0;
    logic [3:0] sci1;
  } iprd_t;

  typedef struct packed {
    logic       nmil;
    logic [5:0] rsv0;
    logic       nmie;
    logic [3:0] irqs;
    logic [3:0] rsv1;
  } icr_t;

  typedef struct packed {
    logic [3:0] lvl;
    logic [7:0] vec;
    logic       vld;
  } src_t;

  localparam int NSRC = 13;

  localparam ipra_t IPRA_INIT = '0;
  localparam iprd_t IPRD_INIT = '0;
  localparam icr_t  ICR_INIT  = '0;

  localparam logic [15:0] IPRA_WMASK = 16'hFFFF;
  localparam logic [15:0] IPRD_WMASK = 16'h00FF;
  localparam logic [15:0] ICR_WMASK  = 16'h01F0;

  localparam logic [23:0] REG_WIN = 24'h5FFFF8;

  localparam logic [7:0] VEC_NMI      = 8'd11;
  localparam logic [7:0] VEC_IRQ0     = 8'd64;
  localparam logic [7:0] VEC_SCI0_ERI = 8'd100;
  localparam logic [7:0] VEC_SCI1_ERI = 8'd104;

  function automatic logic [15:0] wr16(input logic [15:0] old, input logic [15:0] d,
                                       input logic [1:0] be, input logic [15:0] m);
    logic [15:0] k;
    k = {{8{be[1]}}, {8{be[0]}}} & m;
    return (old & ~k) | (d & k);
  endfunction

endpackage

// File: rtl/sh7034_intc_arb.sv
// sh7034_intc_arb: highest-level wins; on equal level the lowest source index wins.
module sh7034_intc_arb
  import sh7034_intc_pkg::*;
(
  input  src_t [NSRC-1:0] src,
  output logic [3:0]      lvl,
  output logic [7:0]      vec
);

  always_comb begin
    lvl = '0;
    vec = '0;
    for (int i = 0; i < NSRC; i++)
      if (src[i].vld && src[i].lvl > lvl) begin
        lvl = src[i].lvl;
        vec = src[i].vec;
      end
  end

endmodule

// File: rtl/sh7034_intc.sv
// sh7034_intc: SH7034 interrupt controller (NMI, IRQ0-3, SCI0/SCI1) with IPRA/IPRD/ICR.
// Optional SH7034_INTC_IRQOUT_EN adds SR_IMASK input and IRQOUT_N output.
module sh7034_intc
  import sh7034_intc_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CE_R,
  input  logic               CE_F,
  input  logic               RES_N,
  input  logic               NMI,
  input  logic [NUM_IRQ-1:0] IRQ_N,
  input  logic [3:0]         SCI0_IRQ,
  input  logic [3:0]         SCI1_IRQ,
  input  logic [27:0]        IBUS_A,
  input  logic [31:0]        IBUS_DI,
  output logic [31:0]        IBUS_DO,
  input  logic [3:0]         IBUS_BA,
  input  logic               IBUS_WE,
  input  logic               IBUS_REQ,
  output logic               IBUS_BUSY,
  output logic               IBUS_ACT,
  output logic [3:0]         INT_LVL,
  output logic [7:0]         INT_VEC,
  output logic               INT_REQ,
  input  logic               INT_ACK
`ifdef SH7034_INTC_IRQOUT_EN
  ,
  input  logic [3:0]         SR_IMASK,
  output logic               IRQOUT_N
`endif
);

  ipra_t ipra;
  iprd_t iprd;
  icr_t icr;
  logic nmi_s1, nmi_s, nmi_d, nmi_lat, nmi_edge, ack, ack_nmi, icr_clr;
  logic reg_sel, sel_ipra, sel_iprd, sel_icr, wr;
  logic [3:0] irq_pin, irq_s1, irq_s, irq_d, irq_lat, irq_set, irq_req, ack_irq, mode;
  logic [3:0][3:0] pri;
  logic [15:0] rd_h;
  logic [31:0] rd_q;
  logic [3:0] arb_lvl;
  logic [7:0] arb_vec;
  src_t [NSRC-1:0] src;
  logic unused_ok;

  assign unused_ok = ^IBUS_A[1:0];

  always_comb begin
    irq_pin = '1;
    irq_pin[NUM_IRQ-1:0] = IRQ_N;
  end

  assign reg_sel  = IBUS_REQ && IBUS_A[27:4] == REG_WIN;
  assign sel_ipra = reg_sel && IBUS_A[3:2] == 2'd1;
  assign sel_iprd = reg_sel && IBUS_A[3:2] == 2'd2;
  assign sel_icr  = reg_sel && IBUS_A[3:2] == 2'd3;
  assign wr       = IBUS_WE;
  assign icr_clr  = wr && sel_icr && IBUS_BA[0];
  assign rd_h     = sel_ipra ? ipra : sel_iprd ? iprd : sel_icr ? {nmi_s, icr[14:0]} : 16'h0;

  assign IBUS_DO   = reg_sel ? rd_q : '0;
  assign IBUS_ACT  = reg_sel;
  assign IBUS_BUSY = 1'b0;

  assign mode     = {icr.irqs[0], icr.irqs[1], icr.irqs[2], icr.irqs[3]};
  assign pri      = {ipra.irq3, ipra.irq2, ipra.irq1, ipra.irq0};
  assign nmi_edge = icr.nmie ? (nmi_s & ~nmi_d) : (~nmi_s & nmi_d);
  assign irq_set  = mode & ~irq_s & irq_d;
  assign irq_req  = (mode & irq_lat) | (~mode & ~irq_s);
  assign ack      = INT_ACK && INT_REQ;
  assign ack_nmi  = ack && INT_VEC == VEC_NMI;

  assign src[0] = {4'hF, VEC_NMI, nmi_lat};
  for (genvar g = 0; g < 4; g++) begin : g_src
    assign ack_irq[g] = ack && INT_VEC == VEC_IRQ0 + 8'(g);
    assign src[1+g] = {pri[g], VEC_IRQ0 + 8'(g), irq_req[g]};
    assign src[5+g] = {iprd.sci0, VEC_SCI0_ERI + 8'(g), SCI0_IRQ[g]};
    assign src[9+g] = {iprd.sci1, VEC_SCI1_ERI + 8'(g), SCI1_IRQ[g]};
  end

  sh7034_intc_arb u_arb (.src(src), .lvl(arb_lvl), .vec(arb_vec));

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      nmi_s1 <= 1'b0;
      nmi_s  <= 1'b0;
      nmi_d  <= 1'b0;
      irq_s1 <= '1;
      irq_s  <= '1;
      irq_d  <= '1;
    end else if (CE_R) begin
      nmi_s1 <= NMI;
      nmi_s  <= nmi_s1;
      nmi_d  <= nmi_s;
      irq_s1 <= irq_pin;
      irq_s  <= irq_s1;
      irq_d  <= irq_s;
    end

  // Set terms are OR-ed last so a new edge survives a same-cycle ack or ICR write.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      ipra    <= IPRA_INIT;
      iprd    <= IPRD_INIT;
      icr     <= ICR_INIT;
      nmi_lat <= 1'b0;
      irq_lat <= '0;
      INT_LVL <= '0;
      INT_VEC <= '0;
      INT_REQ <= 1'b0;
    end else if (CE_R) begin
      if (!RES_N) begin
        ipra    <= IPRA_INIT;
        iprd    <= IPRD_INIT;
        icr     <= ICR_INIT;
        nmi_lat <= 1'b0;
        irq_lat <= '0;
        INT_LVL <= '0;
        INT_VEC <= '0;
        INT_REQ <= 1'b0;
      end else begin
        if (wr && sel_ipra) ipra <= wr16(ipra, IBUS_DI[31:16], IBUS_BA[3:2], IPRA_WMASK);
        if (wr && sel_iprd) iprd <= wr16(iprd, IBUS_DI[15:0], IBUS_BA[1:0], IPRD_WMASK);
        if (wr && sel_icr) icr <= wr16(icr, IBUS_DI[15:0], IBUS_BA[1:0], ICR_WMASK);
        nmi_lat <= (nmi_lat & ~ack_nmi) | nmi_edge;
        irq_lat <= (irq_lat & ~ack_irq & ~{4{icr_clr}}) | irq_set;
        INT_LVL <= arb_lvl;
        INT_VEC <= arb_vec;
        INT_REQ <= arb_lvl != 4'd0;
      end
    end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) rd_q <= '0;
    else if (CE_F) rd_q <= {rd_h, rd_h};

`ifdef SH7034_INTC_IRQOUT_EN
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) IRQOUT_N <= 1'b1;
    else if (CE_R) IRQOUT_N <= !(RES_N && arb_lvl > SR_IMASK);
`endif

endmodule

// File: tb/tb_sh7034_intc.sv
// tb_sh7034_intc: directed scenario tasks for sh7034_intc with hand-computed expectations.
module tb_sh7034_intc;

  localparam logic [27:0] A_IPRA = 28'h5FFFF84;
  localparam logic [27:0] A_IPRD = 28'h5FFFF8A;
  localparam logic [27:0] A_ICR  = 28'h5FFFF8E;

  logic CLK = 1'b0;
  logic RST_N, CE_R, CE_F, RES_N, NMI;
  logic [3:0] IRQ_N, SCI0_IRQ, SCI1_IRQ, IBUS_BA, INT_LVL;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DI, IBUS_DO;
  logic IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT, INT_REQ, INT_ACK;
  logic [7:0] INT_VEC;
`ifdef SH7034_INTC_IRQOUT_EN
  logic [3:0] SR_IMASK = 4'hF;
  logic IRQOUT_N;
`endif
  int checks = 0;
  int errors = 0;

  sh7034_intc #(.NUM_IRQ(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N), .NMI(NMI),
    .IRQ_N(IRQ_N), .SCI0_IRQ(SCI0_IRQ), .SCI1_IRQ(SCI1_IRQ),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
    .INT_LVL(INT_LVL), .INT_VEC(INT_VEC), .INT_REQ(INT_REQ), .INT_ACK(INT_ACK)
`ifdef SH7034_INTC_IRQOUT_EN
    , .SR_IMASK(SR_IMASK), .IRQOUT_N(IRQOUT_N)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST_N = 0; CE_R = 1; CE_F = 1; RES_N = 1; NMI = 0; IRQ_N = '1;
    SCI0_IRQ = '0; SCI1_IRQ = '0; IBUS_A = '0; IBUS_DI = '0; IBUS_BA = '0;
    IBUS_WE = 0; IBUS_REQ = 0; INT_ACK = 0;
    tick(2);
    RST_N = 1;
    tick();
  endtask

  task automatic w16(input logic [27:0] a, input logic [15:0] h);
    IBUS_A = a; IBUS_DI = {h, h}; IBUS_BA = a[1] ? 4'b0011 : 4'b1100;
    IBUS_WE = 1; IBUS_REQ = 1;
    tick();
    IBUS_WE = 0; IBUS_REQ = 0;
  endtask

  task automatic rd(input logic [27:0] a, output logic [31:0] d, output logic act);
    IBUS_A = a; IBUS_WE = 0; IBUS_REQ = 1;
    tick();
    d = IBUS_DO; act = IBUS_ACT;
    IBUS_REQ = 0;
  endtask

  task automatic ack_pulse();
    INT_ACK = 1;
    tick();
    INT_ACK = 0;
    tick();
  endtask

  task automatic wait_for(input logic [7:0] v, input logic r);
    for (int i = 0; i < 10; i++) begin
      if (INT_REQ === r && (!r || INT_VEC === v)) break;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic act;
    do_reset();
    checks++; if (INT_LVL !== 4'd0) begin errors++; $display("FAIL rst_lvl: got %0d want 0", INT_LVL); end
    checks++; if (INT_VEC !== 8'd0) begin errors++; $display("FAIL rst_vec: got %0d want 0", INT_VEC); end
    checks++; if (INT_REQ !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", INT_REQ); end
    checks++; if (IBUS_DO !== 32'h0 || IBUS_BUSY !== 1'b0 || IBUS_ACT !== 1'b0) begin
      errors++; $display("FAIL rst_bus: do=%h busy=%b act=%b want 0/0/0", IBUS_DO, IBUS_BUSY, IBUS_ACT); end
    rd(A_ICR, d, act);
    checks++; if (d !== 32'h0 || act !== 1'b1) begin errors++; $display("FAIL rst_icr: got %h act=%b want 00000000 act=1", d, act); end
    IBUS_DI = 32'hFFFFFFFF; IBUS_BA = 4'hF;
    IBUS_A = A_IPRA;
    SCI0_IRQ = 4'b0010;
    w16(A_IPRD, 16'h00F0);
    tick();
    checks++; if (INT_REQ !== 1'b1 || INT_VEC !== 8'd101) begin
      errors++; $display("FAIL mid_req: req=%b vec=%0d want 1/101", INT_REQ, INT_VEC); end
    RST_N = 0;
    #2;
    checks++; if (INT_REQ !== 1'b0 || INT_LVL !== 4'd0 || INT_VEC !== 8'd0) begin
      errors++; $display("FAIL async_rst: req=%b lvl=%0d vec=%0d want 0/0/0", INT_REQ, INT_LVL, INT_VEC); end
    RST_N = 1;
    tick(2);
    checks++; if (INT_REQ !== 1'b0) begin errors++; $display("FAIL post_rst_req: got %b want 0", INT_REQ); end
    rd(A_IPRD, d, act);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_rst_iprd: got %h want 00000000", d); end
    SCI0_IRQ = '0;
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic act;
    do_reset();
    w16(A_IPRA, 16'hFFFF);
    rd(A_IPRA, d, act);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL ipra_rb: got %h want ffffffff", d); end
    w16(A_IPRD, 16'hFFFF);
    rd(A_IPRD, d, act);
    checks++; if (d !== 32'h00FF00FF) begin errors++; $display("FAIL iprd_rb: got %h want 00ff00ff", d); end
    w16(A_ICR, 16'hFFFF);
    rd(A_ICR, d, act);
    checks++; if (d !== 32'h01F001F0) begin errors++; $display("FAIL icr_rb: got %h want 01f001f0", d); end
    NMI = 1;
    tick(3);
    rd(A_ICR, d, act);
    checks++; if (d !== 32'h81F081F0) begin errors++; $display("FAIL icr_nmil: got %h want 81f081f0", d); end
    NMI = 0;
    rd(28'h5FFFF70, d, act);
    checks++; if (d !== 32'h0 || act !== 1'b0) begin errors++; $display("FAIL out_win: do=%h act=%b want 0/0", d, act); end
    checks++; if (IBUS_DO !== 32'h0) begin errors++; $display("FAIL idle_do: got %h want 0", IBUS_DO); end
    IBUS_A = A_IPRA; IBUS_DI = 32'h12341234; IBUS_BA = 4'b1000; IBUS_WE = 1; IBUS_REQ = 1;
    tick();
    IBUS_WE = 0; IBUS_REQ = 0;
    rd(A_IPRA, d, act);
    checks++; if (d !== 32'h12FF12FF) begin errors++; $display("FAIL ipra_be: got %h want 12ff12ff", d); end
    RES_N = 0;
    tick();
    RES_N = 1;
    rd(A_IPRA, d, act);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL res_n_ipra: got %h want 00000000", d); end
  endtask

  task automatic test_sci();
    do_reset();
    w16(A_IPRD, 16'h0053);
    CE_R = 0;
    SCI0_IRQ = 4'b0010;
    tick(2);
    checks++; if (INT_REQ !== 1'b0) begin errors++; $display("FAIL ce_hold: req=%b want 0", INT_REQ); end
    CE_R = 1;
    tick();
    checks++; if (INT_LVL !== 4'd5 || INT_VEC !== 8'd101 || INT_REQ !== 1'b1) begin
      errors++; $display("FAIL sci0_rxi: lvl=%0d vec=%0d req=%b want 5/101/1", INT_LVL, INT_VEC, INT_REQ); end
    SCI1_IRQ = 4'b1000;
    tick();
    checks++; if (INT_VEC !== 8'd101) begin errors++; $display("FAIL sci_prio: vec=%0d want 101", INT_VEC); end
    SCI0_IRQ = '0;
    tick();
    checks++; if (INT_LVL !== 4'd3 || INT_VEC !== 8'd107) begin
      errors++; $display("FAIL sci1_tei: lvl=%0d vec=%0d want 3/107", INT_LVL, INT_VEC); end
    SCI1_IRQ = '0;
    tick();
    checks++; if (INT_REQ !== 1'b0 || INT_LVL !== 4'd0) begin
      errors++; $display("FAIL sci_off: req=%b lvl=%0d want 0/0", INT_REQ, INT_LVL); end
  endtask

  task automatic test_irq_edge();
    do_reset();
    w16(A_ICR, 16'h0080);
    w16(A_IPRA, 16'h3000);
    IRQ_N[0] = 0;
    wait_for(8'd64, 1'b1);
    checks++; if (INT_LVL !== 4'd3 || INT_VEC !== 8'd64 || INT_REQ !== 1'b1) begin
      errors++; $display("FAIL irq0_edge: lvl=%0d vec=%0d req=%b want 3/64/1", INT_LVL, INT_VEC, INT_REQ); end
    ack_pulse();
    checks++; if (INT_REQ !== 1'b0) begin errors++; $display("FAIL irq0_ack: req=%b want 0", INT_REQ); end
    tick(3);
    checks++; if (INT_REQ !== 1'b0) begin errors++; $display("FAIL irq0_stay: req=%b want 0", INT_REQ); end
    IRQ_N[0] = 1;
    tick(4);
    IRQ_N[0] = 0;
    wait_for(8'd64, 1'b1);
    IRQ_N[0] = 1;
    tick(4);
    w16(A_ICR, 16'h0080);
    tick(2);
    checks++; if (INT_REQ !== 1'b0) begin errors++; $display("FAIL icr_clr: req=%b want 0", INT_REQ); end
  endtask

  task automatic test_irq_level();
    do_reset();
    w16(A_IPRA, 16'h0200);
    IRQ_N[1] = 0;
    wait_for(8'd65, 1'b1);
    checks++; if (INT_LVL !== 4'd2 || INT_VEC !== 8'd65) begin
      errors++; $display("FAIL irq1_lvl: lvl=%0d vec=%0d want 2/65", INT_LVL, INT_VEC); end
    ack_pulse();
    checks++; if (INT_REQ !== 1'b1 || INT_VEC !== 8'd65) begin
      errors++; $display("FAIL irq1_persist: req=%b vec=%0d want 1/65", INT_REQ, INT_VEC); end
    IRQ_N[1] = 1;
    wait_for(8'd0, 1'b0);
    checks++; if (INT_REQ !== 1'b0) begin errors++; $display("FAIL irq1_release: req=%b want 0", INT_REQ); end
  endtask

  task automatic test_tie();
    do_reset();
    w16(A_ICR, 16'h0080);
    w16(A_IPRA, 16'h4000);
    w16(A_IPRD, 16'h0004);
    SCI1_IRQ = 4'b0001;
    tick();
    checks++; if (INT_VEC !== 8'd104 || INT_LVL !== 4'd4) begin
      errors++; $display("FAIL tie_sci1: vec=%0d lvl=%0d want 104/4", INT_VEC, INT_LVL); end
    IRQ_N[0] = 0;
    wait_for(8'd64, 1'b1);
    checks++; if (INT_VEC !== 8'd64 || INT_LVL !== 4'd4) begin
      errors++; $display("FAIL tie_irq0: vec=%0d lvl=%0d want 64/4", INT_VEC, INT_LVL); end
    ack_pulse();
    checks++; if (INT_VEC !== 8'd104 || INT_LVL !== 4'd4) begin
      errors++; $display("FAIL tie_after_ack: vec=%0d lvl=%0d want 104/4", INT_VEC, INT_LVL); end
    SCI1_IRQ = '0;
  endtask

  task automatic test_nmi();
    do_reset();
    w16(A_ICR, 16'h0100);
    w16(A_IPRD, 16'h00F0);
    SCI0_IRQ = 4'b0001;
    tick();
    checks++; if (INT_VEC !== 8'd100 || INT_LVL !== 4'd15) begin
      errors++; $display("FAIL nmi_pre: vec=%0d lvl=%0d want 100/15", INT_VEC, INT_LVL); end
    NMI = 1;
    wait_for(8'd11, 1'b1);
    checks++; if (INT_VEC !== 8'd11 || INT_LVL !== 4'd15) begin
      errors++; $display("FAIL nmi_win: vec=%0d lvl=%0d want 11/15", INT_VEC, INT_LVL); end
    ack_pulse();
    checks++; if (INT_VEC !== 8'd100 || INT_LVL !== 4'd15) begin
      errors++; $display("FAIL nmi_ack: vec=%0d lvl=%0d want 100/15", INT_VEC, INT_LVL); end
    NMI = 0;
    tick(4);
    checks++; if (INT_VEC !== 8'd100) begin errors++; $display("FAIL nmi_fall_ignored: vec=%0d want 100", INT_VEC); end
    SCI0_IRQ = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    w16(A_ICR, 16'h0080);
    w16(A_IPRA, 16'h3000);
    IRQ_N[0] = 0;
    wait_for(8'd64, 1'b1);
    IRQ_N[0] = 1;
    tick(4);
    IRQ_N[0] = 0;
    tick(2);
    INT_ACK = 1;
    tick();
    INT_ACK = 0;
    tick();
    checks++; if (INT_REQ !== 1'b1 || INT_VEC !== 8'd64) begin
      errors++; $display("FAIL set_wins: req=%b vec=%0d want 1/64", INT_REQ, INT_VEC); end
    tick(3);
    checks++; if (INT_REQ !== 1'b1 || INT_VEC !== 8'd64) begin
      errors++; $display("FAIL set_wins_hold: req=%b vec=%0d want 1/64", INT_REQ, INT_VEC); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_sci();
    test_irq_edge();
    test_irq_level();
    test_tie();
    test_nmi();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
